// File: rtl/elbeth_branch_ctrl.sv
// ID-stage branch sequencing: operand-hazard stall, branch resolve, registered
// PC redirect held until fetch accepts, wrong-path squash and perf counters.
module elbeth_branch_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_branch_valid,
    input  logic [2:0]           i_id_operation,
    input  logic                 i_id_rs1_hazard,
    input  logic                 i_id_rs2_hazard,
    input  logic                 i_branch_taken,
    input  logic [31:0]          i_pc_branch,
    input  logic                 i_imem_ready,
    input  logic                 i_ex_flush,
    output logic                 o_id_stall,
    output logic                 o_if_flush,
    output logic                 o_pc_redirect_valid,
    output logic [31:0]          o_pc_redirect,
    output logic                 o_branch_misaligned,
    output logic [CNT_WIDTH-1:0] o_perf_branches,
    output logic [CNT_WIDTH-1:0] o_perf_taken
);

    // Branch-unit operation codes, same order as the ELBETH definitions.
    localparam logic [2:0] OP_JAL  = 3'd0;
    localparam logic [2:0] OP_JALR = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_BLT  = 3'd4;
    localparam logic [2:0] OP_BGE  = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;
    localparam logic [2:0] OP_BGEU = 3'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // state     | meaning
    // IDLE      | no branch in flight
    // WAIT_OPND | branch in ID stalled on a needed operand hazard
    // REDIRECT  | redirect to fetch pending, IF/ID squashed
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]          r_target;
    logic                 r_misaligned;
    logic [CNT_WIDTH-1:0] r_perf_branches;
    logic [CNT_WIDTH-1:0] r_perf_taken;

    logic w_need_rs1;
    logic w_need_rs2;
    logic w_hazard;
    logic w_resolve;
    logic w_aligned;
    logic w_take;
    logic w_stall;

    always_comb begin
        w_need_rs1 = 1'b1;
        w_need_rs2 = 1'b1;
        case (i_id_operation)
            OP_JAL:  begin w_need_rs1 = 1'b0; w_need_rs2 = 1'b0; end
            OP_JALR: begin w_need_rs2 = 1'b0; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: ;
            default: ;
        endcase
    end

    assign w_hazard  = (w_need_rs1 & i_id_rs1_hazard) | (w_need_rs2 & i_id_rs2_hazard);
    assign w_aligned = (i_pc_branch[1:0] == 2'b00);
    assign w_take    = w_resolve & i_branch_taken & w_aligned;

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_resolve    = 1'b0;
        if (!i_ex_flush) begin
            case (r_state)
                IDLE: begin
                    if (i_id_branch_valid) begin
                        if (w_hazard) begin
                            w_stall      = 1'b1;
                            w_state_next = WAIT_OPND;
                        end else begin
                            w_resolve = 1'b1;
                        end
                    end
                end
                WAIT_OPND: begin
                    if (!i_id_branch_valid) begin
                        w_state_next = IDLE;
                    end else if (w_hazard) begin
                        w_stall = 1'b1;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
                REDIRECT: begin
                    // The ID instruction is wrong-path here, so it is never looked at.
                    if (i_imem_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
            if (w_resolve) begin
                w_state_next = (i_branch_taken && w_aligned) ? REDIRECT : IDLE;
            end
        end else begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_target        <= 32'd0;
            r_misaligned    <= 1'b0;
            r_perf_branches <= '0;
            r_perf_taken    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_misaligned <= w_resolve & i_branch_taken & ~w_aligned;
            if (w_resolve) begin
                r_perf_branches <= r_perf_branches + CNT_ONE;
            end
            if (w_take) begin
                r_target     <= i_pc_branch;
                r_perf_taken <= r_perf_taken + CNT_ONE;
            end
        end
    end

    assign o_id_stall          = w_stall;
    assign o_pc_redirect_valid = (r_state == REDIRECT);
    assign o_if_flush          = (r_state == REDIRECT);
    assign o_pc_redirect       = r_target;
    assign o_branch_misaligned = r_misaligned;
    assign o_perf_branches     = r_perf_branches;
    assign o_perf_taken        = r_perf_taken;

endmodule

// File: tb/tb_elbeth_branch_ctrl.sv
// Directed self-checking bench for elbeth_branch_ctrl (4-bit counters so the
// wrap case is reachable); expected values are hand-derived constants.
module tb_elbeth_branch_ctrl;

    localparam int CW = 4;

    localparam logic [2:0] OP_JAL  = 3'd0;
    localparam logic [2:0] OP_JALR = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_BGE  = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_id_branch_valid;
    logic [2:0]    i_id_operation;
    logic          i_id_rs1_hazard;
    logic          i_id_rs2_hazard;
    logic          i_branch_taken;
    logic [31:0]   i_pc_branch;
    logic          i_imem_ready;
    logic          i_ex_flush;
    logic          o_id_stall;
    logic          o_if_flush;
    logic          o_pc_redirect_valid;
    logic [31:0]   o_pc_redirect;
    logic          o_branch_misaligned;
    logic [CW-1:0] o_perf_branches;
    logic [CW-1:0] o_perf_taken;

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_tk   = 0;

    elbeth_branch_ctrl #(.CNT_WIDTH(CW)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_id_branch_valid   (i_id_branch_valid),
        .i_id_operation      (i_id_operation),
        .i_id_rs1_hazard     (i_id_rs1_hazard),
        .i_id_rs2_hazard     (i_id_rs2_hazard),
        .i_branch_taken      (i_branch_taken),
        .i_pc_branch         (i_pc_branch),
        .i_imem_ready        (i_imem_ready),
        .i_ex_flush          (i_ex_flush),
        .o_id_stall          (o_id_stall),
        .o_if_flush          (o_if_flush),
        .o_pc_redirect_valid (o_pc_redirect_valid),
        .o_pc_redirect       (o_pc_redirect),
        .o_branch_misaligned (o_branch_misaligned),
        .o_perf_branches     (o_perf_branches),
        .o_perf_taken        (o_perf_taken)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_id_branch_valid = 1'b0;
        i_id_operation    = OP_JAL;
        i_id_rs1_hazard   = 1'b0;
        i_id_rs2_hazard   = 1'b0;
        i_branch_taken    = 1'b0;
        i_pc_branch       = 32'd0;
        i_imem_ready      = 1'b0;
        i_ex_flush        = 1'b0;
    endtask

    task automatic branch(input logic [2:0] op, input logic taken, input logic [31:0] pc);
        i_id_branch_valid = 1'b1;
        i_id_operation    = op;
        i_branch_taken    = taken;
        i_pc_branch       = pc;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_br"}, 32'(o_perf_branches), 32'(exp_br % 16));
        chk({tag, "_tk"}, 32'(o_perf_taken), 32'(exp_tk % 16));
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b1;
        step();
        step();
        chk("rst_stall", 32'(o_id_stall), 32'd0);
        chk("rst_flush", 32'(o_if_flush), 32'd0);
        chk("rst_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk("rst_target", o_pc_redirect, 32'd0);
        chk("rst_mis", 32'(o_branch_misaligned), 32'd0);
        chk_counts("rst");
        i_rst = 1'b0;

        // JAL to a misaligned target: pulse only, no redirect.
        branch(OP_JAL, 1'b1, 32'hFFFF_00F2);
        #1 chk("jalmis_stall", 32'(o_id_stall), 32'd0);
        step();
        exp_br++;
        idle_inputs();
        chk("jalmis_pulse", 32'(o_branch_misaligned), 32'd1);
        chk("jalmis_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("jalmis");
        step();
        chk("jalmis_pulse_end", 32'(o_branch_misaligned), 32'd0);

        // JAL aligned, fetch accepts at once: single-cycle redirect.
        branch(OP_JAL, 1'b1, 32'hFFFF_00F4);
        step();
        exp_br++; exp_tk++;
        idle_inputs();
        i_imem_ready = 1'b1;
        chk("jal_rvalid", 32'(o_pc_redirect_valid), 32'd1);
        chk("jal_flush", 32'(o_if_flush), 32'd1);
        chk("jal_target", o_pc_redirect, 32'hFFFF_00F4);
        chk("jal_mis", 32'(o_branch_misaligned), 32'd0);
        chk_counts("jal");
        step();
        i_imem_ready = 1'b0;
        chk("jal_rvalid_end", 32'(o_pc_redirect_valid), 32'd0);

        // BEQ stalled two cycles on rs2, resolves on the third.
        branch(OP_BEQ, 1'b1, 32'h0000_0100);
        i_id_rs2_hazard = 1'b1;
        #1 chk("beq_stall1", 32'(o_id_stall), 32'd1);
        step();
        #1 chk("beq_stall2", 32'(o_id_stall), 32'd1);
        chk_counts("beq_wait");
        step();
        i_id_rs2_hazard = 1'b0;
        #1 chk("beq_stall3", 32'(o_id_stall), 32'd0);
        chk("beq_rvalid3", 32'(o_pc_redirect_valid), 32'd0);
        step();
        exp_br++; exp_tk++;
        idle_inputs();
        i_imem_ready = 1'b1;
        chk("beq_rvalid4", 32'(o_pc_redirect_valid), 32'd1);
        chk("beq_target", o_pc_redirect, 32'h0000_0100);
        chk_counts("beq");
        step();
        idle_inputs();

        // JALR ignores a hazard on rs2.
        branch(OP_JALR, 1'b0, 32'h0000_0200);
        i_id_rs2_hazard = 1'b1;
        #1 chk("jalr_stall", 32'(o_id_stall), 32'd0);
        step();
        exp_br++;
        idle_inputs();
        chk("jalr_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("jalr");

        // BLTU taken, fetch busy for 3 cycles; a new branch in ID is ignored.
        branch(OP_BLTU, 1'b1, 32'h0000_2000);
        step();
        exp_br++; exp_tk++;
        branch(OP_JAL, 1'b1, 32'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            i_imem_ready = (i == 3);
            #1;
            chk("bltu_rvalid", 32'(o_pc_redirect_valid), 32'd1);
            chk("bltu_flush", 32'(o_if_flush), 32'd1);
            chk("bltu_target", o_pc_redirect, 32'h0000_2000);
            chk("bltu_stall", 32'(o_id_stall), 32'd0);
            chk_counts("bltu_win");
            step();
        end
        idle_inputs();
        chk("bltu_rvalid_end", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("bltu");

        // BNE not taken.
        branch(OP_BNE, 1'b0, 32'h0000_0400);
        step();
        exp_br++;
        idle_inputs();
        chk("bne_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk("bne_flush", 32'(o_if_flush), 32'd0);
        chk_counts("bne");

        // ex_flush during WAIT_OPND aborts the wait uncounted.
        branch(OP_BGE, 1'b1, 32'h0000_0500);
        i_id_rs1_hazard = 1'b1;
        #1 chk("exw_stall", 32'(o_id_stall), 32'd1);
        step();
        i_ex_flush = 1'b1;
        #1 chk("exw_stall_flush", 32'(o_id_stall), 32'd0);
        step();
        idle_inputs();
        chk("exw_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("exw");

        // ex_flush coincident with a resolve: branch not counted.
        branch(OP_JAL, 1'b1, 32'h0000_0600);
        i_ex_flush = 1'b1;
        step();
        idle_inputs();
        chk("exr_rvalid", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("exr");

        // ex_flush during REDIRECT drops the redirect.
        branch(OP_BEQ, 1'b1, 32'h0000_0700);
        step();
        exp_br++; exp_tk++;
        idle_inputs();
        chk("exrd_rvalid", 32'(o_pc_redirect_valid), 32'd1);
        i_ex_flush = 1'b1;
        step();
        idle_inputs();
        chk("exrd_rvalid_end", 32'(o_pc_redirect_valid), 32'd0);
        chk_counts("exrd");

        // rst during REDIRECT clears everything.
        branch(OP_JAL, 1'b1, 32'h0000_0800);
        step();
        exp_br++; exp_tk++;
        idle_inputs();
        chk("rstrd_rvalid", 32'(o_pc_redirect_valid), 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_br = 0; exp_tk = 0;
        chk("rstrd_rvalid_end", 32'(o_pc_redirect_valid), 32'd0);
        chk("rstrd_flush", 32'(o_if_flush), 32'd0);
        chk("rstrd_target", o_pc_redirect, 32'd0);
        chk_counts("rstrd");

        // 16 taken JALs (hazards asserted but irrelevant) wrap both counters.
        for (int i = 0; i < 16; i++) begin
            branch(OP_JAL, 1'b1, 32'h0001_0000 + 32'(i * 4));
            i_id_rs1_hazard = 1'b1;
            i_id_rs2_hazard = 1'b1;
            #1 chk("wrap_stall", 32'(o_id_stall), 32'd0);
            step();
            exp_br++; exp_tk++;
            idle_inputs();
            i_imem_ready = 1'b1;
            chk("wrap_target", o_pc_redirect, 32'h0001_0000 + 32'(i * 4));
            if (i == 14) begin
                chk("wrap_br15", 32'(o_perf_branches), 32'd15);
                chk("wrap_tk15", 32'(o_perf_taken), 32'd15);
            end
            step();
            idle_inputs();
        end
        chk("wrap_br0", 32'(o_perf_branches), 32'd0);
        chk("wrap_tk0", 32'(o_perf_taken), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elbeth_branch_ctrl.md
# elbeth_branch_ctrl

Sequencing controller for the ELBETH ID-stage branch unit. It watches each decoded JAL/JALR/Bxx instruction and stalls ID until its source operands can be forwarded. It then samples the branch unit's `branch_taken`/`pc_branch` result and drives a registered PC redirect to the fetch stage, holding it until instruction memory accepts. While the redirect is pending it squashes the wrong-path IF/ID instruction and maintains branch/taken performance counters.

## Interface
- `CNT_WIDTH`, default 32: width of each performance counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_branch_valid`  in  1  instruction in ID is JAL, JALR or a conditional branch.
- `id_operation`  in  3  branch-unit operation code (`OP_JAL` … `OP_BGEU`, from `elbeth_definitions.v`).
- `id_rs1_hazard`  in  1  rs1 value not yet forwardable (e.g. load in EX).
- `id_rs2_hazard`  in  1  rs2 value not yet forwardable.
- `branch_taken`  in  1  branch-unit result, combinational from ID operands.
- `pc_branch`  in  32  branch-unit target address.
- `imem_ready`  in  1  fetch stage accepts a redirect this cycle.
- `ex_flush`  in  1  higher-priority flush (exception or trap) from a later stage.
- `id_stall`  out  1  hold PC and IF/ID.
- `if_flush`  out  1  convert the IF/ID instruction to a bubble.
- `pc_redirect_valid`  out  1  redirect request to fetch.
- `pc_redirect`  out  32  redirect target.
- `branch_misaligned`  out  1  one-cycle pulse: taken target not word aligned.
- `perf_branches`  out  CNT_WIDTH  resolved branch/jump count.
- `perf_taken`  out  CNT_WIDTH  taken, redirected count.

## Operation
- **States:** IDLE, WAIT_OPND, REDIRECT.
- **Operand need by operation:**
  - JAL needs no operands.
  - JALR needs rs1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU need rs1 and rs2.
  - A hazard on an operand the instruction does not need is ignored.
- **IDLE:**
  - If `id_branch_valid` is set and a needed hazard is high: go to WAIT_OPND. `id_stall`=1 combinationally in the same cycle.
  - If `id_branch_valid` is set and no needed hazard is high: **resolve** this cycle.
- **WAIT_OPND:**
  - `id_stall`=1 while any needed hazard is high.
  - When all needed hazards are low: `id_stall`=0 and resolve this cycle.
  - `id_branch_valid` low in this state (cannot occur legally): return to IDLE.
- **Resolve (cycle T):**
  - `perf_branches` increments.
  - Taken and `pc_branch[1:0]`==0: capture `pc_branch` into the target register, increment `perf_taken`, next state REDIRECT.
  - Taken and misaligned: `branch_misaligned`=1 at T+1 for one cycle, no redirect, `perf_taken` unchanged, next state IDLE.
  - Not taken: next state IDLE, nothing else happens.
- **REDIRECT:**
  - `pc_redirect_valid`=1 and `if_flush`=1 every cycle.
  - `pc_redirect` holds the captured target.
  - `id_branch_valid` is ignored, because the ID instruction is wrong-path.
  - Leaves to IDLE after the cycle in which `imem_ready`=1.
- **`ex_flush` priority:** `ex_flush` overrides everything in any state.
  - Next state IDLE.
  - No resolve, no counter update, no misaligned pulse.
  - A pending redirect is dropped.
  - `id_stall`=0 combinationally.
- **Counters:** free-running, wrap from all-ones to 0; no saturation.

## Timing
- **Reset values:** all outputs 0, including `pc_redirect`, both counters and the target register. State is IDLE.
- **Reset mid-operation:** `rst` in REDIRECT or WAIT_OPND returns to IDLE next edge; outputs are 0 from that edge.
- **Resolve latency:** redirect asserted exactly one cycle after resolve. `pc_redirect_valid` and `if_flush` are registered (state-decoded).
- **Minimum redirect:** `imem_ready`=1 at T+1 gives a single-cycle redirect; IDLE at T+2; a new branch can resolve at T+2.
- **Stall timing:** `id_stall` is combinational from state, hazards, `id_operation` and `ex_flush`; the counters are not updated on stall cycles.
- **Simultaneous `ex_flush` and resolve:** `ex_flush` wins; the branch is not counted.
- **Simultaneous `ex_flush` and `imem_ready` in REDIRECT:** IDLE next cycle either way.

## Test plan
- **JAL, no hazard:** `pc_branch`=0xFFFF00F2 → `branch_misaligned` pulse at T+1, no redirect. Then `pc_branch`=0xFFFF00F4 with `imem_ready`=1 → redirect 0xFFFF00F4 for one cycle, `perf_branches`=2, `perf_taken`=1.
- **BEQ with `id_rs2_hazard` high for 2 cycles:** `id_stall`=1 for 2 cycles; resolves on cycle 3. Taken, `pc_branch`=0x100 → redirect 0x100 at cycle 4.
- **JALR with `id_rs2_hazard`=1 and `id_rs1_hazard`=0:** no stall; resolves immediately.
- **BLTU taken, target 0x2000, `imem_ready` low for 3 cycles:** `pc_redirect_valid` and `if_flush` high 4 cycles, target stable. A new `id_branch_valid` during that window is ignored.
- **BNE not taken:** no redirect, no flush; `perf_branches`+1, `perf_taken` unchanged.
- **`ex_flush` during WAIT_OPND, and separately during REDIRECT:** IDLE next cycle, counters unchanged by the aborted wait. **`rst` during REDIRECT:** all outputs 0 next cycle.
- **Counter wrap with `CNT_WIDTH`=4:** 16 taken branches → both counters wrap to 0.
